reaction_timer_mc: RTL and testbench
====================================

REACTION_TIMER_MC -- requirements
Module: reaction_timer_mc

Interface
REQ-001 SHALL provide parameters, one per line: WIDTH, 16, time counter width in ticks; NCH, 2, number of response channels (1..8); DLY_W, 16, stimulus delay width.
REQ-002 SHALL have ports, one per line: clk  in  1  single system clock, all state on posedge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 tick  in  1  one-cycle timebase enable (1 ms nominal); counters advance only on tick.
REQ-005 start  in  1  one-cycle pulse, begins a trial.
REQ-006 delay  in  DLY_W  stimulus delay in ticks, sampled on accepted start.
REQ-007 resp  in  NCH  per-channel response level, already synchronised, active-high.
REQ-008 lamp  out  1  stimulus indicator.
REQ-009 busy  out  1  high in DELAY or RUN.
REQ-010 done  out  1  high in DONE.
REQ-011 rtime  out  NCH*WIDTH  captured reaction time per channel, channel i at bits [i*WIDTH +: WIDTH].
REQ-012 valid  out  NCH  channel captured a legal response this trial.
REQ-013 fstart  out  NCH  channel responded before lamp.
REQ-014 winner  out  3  index of fastest valid channel; win_ok  out  1  at least one valid channel.
REQ-015 best  out  WIDTH  minimum valid rtime since reset.

Function
REQ-016 FSM states SHALL be IDLE, DELAY, RUN, DONE.
REQ-017 IDLE: start -> DELAY, load delay counter with delay, clear rtime/valid/fstart/win_ok.
REQ-018 DELAY: counter decrements on tick; tick with counter==0 -> RUN next cycle; delay=0 enters RUN on the first tick after start.
REQ-019 RUN: lamp=1; elapsed counter starts at 0, increments on tick, saturates at 2^WIDTH-1 (no wrap).
REQ-020 Response edge SHALL be rising edge of resp[i] (registered previous value); level held across start does not count.
REQ-021 Rising edge in DELAY sets fstart[i]; that channel is ignored for the rest of the trial.
REQ-022 First rising edge in RUN on a channel without fstart SHALL capture the elapsed count, set valid[i]; later edges ignored.
REQ-023 Edge and tick in the same cycle: capture the pre-increment count.
REQ-024 RUN -> DONE when every channel is valid or fstart, or the elapsed counter is saturated; all-fstart in DELAY -> DONE directly, lamp never lit.
REQ-025 DONE: outputs held; winner = lowest rtime among valid channels, ties to lowest index; win_ok=0, winner=0 if none valid; best updated once on entry if winner rtime < best.
REQ-026 start in DONE SHALL behave as start in IDLE; start in DELAY/RUN ignored.
REQ-027 winner/win_ok/best SHALL be registered, valid in the first DONE cycle.

Reset
REQ-028 rst SHALL force IDLE, lamp=0, busy=0, done=0, rtime=0, valid=0, fstart=0, winner=0, win_ok=0, best=all-ones, counters=0, resp history=0, immediately and mid-trial.
REQ-029 First start after rst release SHALL be accepted normally.

Structure
REQ-030 Package rt_pkg SHALL hold the state enum and the maximum-NCH constant.
REQ-031 One sub-module rt_channel SHALL hold per-channel edge detect, fstart, valid and capture register, instantiated NCH times by generate.
REQ-032 Winner and best comparison SHALL stay in the top level.

Verification
REQ-033 NCH=2, delay=3, ch0 edge at elapsed 5, ch1 at 9 -> rtime0=5, rtime1=9, winner=0, best=5, done.
REQ-034 ch1 edge during DELAY, ch0 at elapsed 4 -> fstart=2'b10, valid=2'b01, winner=0.
REQ-035 both channels edge on same cycle at elapsed 7 with tick -> rtime both 7, winner=0.
REQ-036 WIDTH=4, no responses -> elapsed saturates at 15, DONE, win_ok=0, best unchanged all-ones.
REQ-037 rst asserted in RUN -> all outputs reset values same cycle; new start with delay=0 -> lamp on first tick.

Source files
------------

// File: rtl/rt_pkg.sv
// rtl/rt_pkg.sv - shared types and constants for the reaction timer
// Holds the trial FSM state encoding and the channel-count limit.
package rt_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } rt_state_e;

    // Upper bound on response channels; also sizes the winner index.
    localparam int RT_MAX_NCH = 8;
    localparam int RT_WIN_W   = $clog2(RT_MAX_NCH);

endpackage

// File: rtl/rt_channel.sv
// rtl/rt_channel.sv - one response channel: edge detect, false-start flag, capture
// Ports: clk, rst (async, active-high); clear wipes the trial result;
// in_delay / in_run qualify the rising edge of resp; elapsed is the running
// count captured into rtime on the first legal edge; valid / fstart report it.
module rt_channel #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_delay,
    input  logic             in_run,
    input  logic             resp,
    input  logic [WIDTH-1:0] elapsed,
    output logic [WIDTH-1:0] rtime,
    output logic             valid,
    output logic             fstart
);

    logic resp_q;
    logic rise;

    // History runs continuously, so a level held across start is not an edge.
    assign rise = resp & ~resp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_q <= 1'b0;
        end else begin
            resp_q <= resp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rtime  <= '0;
            valid  <= 1'b0;
            fstart <= 1'b0;
        end else if (clear) begin
            rtime  <= '0;
            valid  <= 1'b0;
            fstart <= 1'b0;
        end else begin
            if (in_delay && rise) begin
                fstart <= 1'b1;
            end
            // Only the first legal edge counts; a false start locks the channel out.
            if (in_run && rise && !fstart && !valid) begin
                valid <= 1'b1;
                rtime <= elapsed;
            end
        end
    end

endmodule

// File: rtl/reaction_timer_mc.sv
// rtl/reaction_timer_mc.sv - multi-channel reaction timer top level
// Ports: clk, rst (async, active-high), tick timebase enable, start pulse with
// delay, per-channel resp levels; lamp/busy/done status, packed per-channel
// rtime, valid, fstart, registered winner/win_ok and best-since-reset.
module reaction_timer_mc
    import rt_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NCH   = 2,
    parameter int DLY_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 start,
    input  logic [DLY_W-1:0]     delay,
    input  logic [NCH-1:0]       resp,
    output logic                 lamp,
    output logic                 busy,
    output logic                 done,
    output logic [NCH*WIDTH-1:0] rtime,
    output logic [NCH-1:0]       valid,
    output logic [NCH-1:0]       fstart,
    output logic [RT_WIN_W-1:0]  winner,
    output logic                 win_ok,
    output logic [WIDTH-1:0]     best
);

    localparam logic [WIDTH-1:0] SAT = '1;

    rt_state_e         state;
    rt_state_e         state_nxt;
    logic [DLY_W-1:0]  dcnt;
    logic [WIDTH-1:0]  ecnt;
    logic              accept;
    logic              sat;
    logic              all_settled;
    logic              run_cap;
    logic              enter_done;
    logic [WIDTH-1:0]  cand_rt;
    logic              cand_ok;
    logic [RT_WIN_W-1:0] cand_idx;

    assign accept      = start && ((state == S_IDLE) || (state == S_DONE));
    assign sat         = (ecnt == SAT);
    assign all_settled = &(valid | fstart);
    assign enter_done  = (state_nxt == S_DONE) && (state != S_DONE);
    // No capture on the cycle that leaves RUN, so winner sees the final set.
    assign run_cap     = (state == S_RUN) && (state_nxt == S_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_DELAY;
            S_DELAY: begin
                if (&fstart) begin
                    state_nxt = S_DONE;
                end else if (tick && (dcnt == '0)) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN:   if (all_settled || sat) state_nxt = S_DONE;
            S_DONE:  if (accept) state_nxt = S_DELAY;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        lamp = (state == S_RUN);
        busy = (state == S_DELAY) || (state == S_RUN);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt <= '0;
            ecnt <= '0;
        end else begin
            if (accept) begin
                dcnt <= delay;
            end else if ((state == S_DELAY) && tick && (dcnt != '0)) begin
                dcnt <= dcnt - 1'b1;
            end
            // Elapsed count restarts from zero on every entry to RUN.
            if (state != S_RUN) begin
                ecnt <= '0;
            end else if (tick && !sat) begin
                ecnt <= ecnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        rt_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .clear   (accept),
            .in_delay(state == S_DELAY),
            .in_run  (run_cap),
            .resp    (resp[i]),
            .elapsed (ecnt),
            .rtime   (rtime[i*WIDTH +: WIDTH]),
            .valid   (valid[i]),
            .fstart  (fstart[i])
        );
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        cand_rt  = '1;
        cand_ok  = 1'b0;
        cand_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (valid[i] && (!cand_ok || (rtime[i*WIDTH +: WIDTH] < cand_rt))) begin
                cand_rt  = rtime[i*WIDTH +: WIDTH];
                cand_ok  = 1'b1;
                cand_idx = RT_WIN_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winner <= '0;
            win_ok <= 1'b0;
            best   <= '1;
        end else if (accept) begin
            winner <= '0;
            win_ok <= 1'b0;
        end else if (enter_done) begin
            winner <= cand_idx;
            win_ok <= cand_ok;
            if (cand_ok && (cand_rt < best)) begin
                best <= cand_rt;
            end
        end
    end

endmodule

// File: tb/tb_reaction_timer_mc.sv
// tb/tb_reaction_timer_mc.sv - scoreboard bench for reaction_timer_mc
module tb_reaction_timer_mc;

    typedef struct {
        logic [15:0] rt0;
        logic [15:0] rt1;
        logic [1:0]  valid;
        logic [1:0]  fstart;
        logic [2:0]  winner;
        logic        win_ok;
        logic [15:0] best;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        start16 = 1'b0;
    logic        start4 = 1'b0;
    logic [15:0] delay = '0;
    logic [1:0]  resp16 = '0;
    logic [1:0]  resp4 = '0;

    logic        lamp16, busy16, done16, win_ok16;
    logic [31:0] rtime16;
    logic [1:0]  valid16, fstart16;
    logic [2:0]  winner16;
    logic [15:0] best16;

    logic        lamp4, busy4, done4, win_ok4;
    logic [7:0]  rtime4;
    logic [1:0]  valid4, fstart4;
    logic [2:0]  winner4;
    logic [3:0]  best4;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t q16[$];
    exp_t q4[$];
    logic done16_q = 1'b0;
    logic done4_q  = 1'b0;

    always #5 clk = ~clk;

    reaction_timer_mc #(.WIDTH(16), .NCH(2), .DLY_W(16)) dut16 (
        .clk(clk), .rst(rst), .tick(tick), .start(start16), .delay(delay),
        .resp(resp16), .lamp(lamp16), .busy(busy16), .done(done16),
        .rtime(rtime16), .valid(valid16), .fstart(fstart16),
        .winner(winner16), .win_ok(win_ok16), .best(best16)
    );

    reaction_timer_mc #(.WIDTH(4), .NCH(2), .DLY_W(16)) dut4 (
        .clk(clk), .rst(rst), .tick(tick), .start(start4), .delay(delay),
        .resp(resp4), .lamp(lamp4), .busy(busy4), .done(done4),
        .rtime(rtime4), .valid(valid4), .fstart(fstart4),
        .winner(winner4), .win_ok(win_ok4), .best(best4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_result(input string tag, input exp_t a, input exp_t e);
        chk({tag, "_rt0"},    {16'b0, a.rt0},     {16'b0, e.rt0});
        chk({tag, "_rt1"},    {16'b0, a.rt1},     {16'b0, e.rt1});
        chk({tag, "_valid"},  {30'b0, a.valid},   {30'b0, e.valid});
        chk({tag, "_fstart"}, {30'b0, a.fstart},  {30'b0, e.fstart});
        chk({tag, "_winner"}, {29'b0, a.winner},  {29'b0, e.winner});
        chk({tag, "_win_ok"}, {31'b0, a.win_ok},  {31'b0, e.win_ok});
        chk({tag, "_best"},   {16'b0, a.best},    {16'b0, e.best});
    endtask

    // Monitors: compare on the first DONE cycle of each trial.
    always @(negedge clk) begin
        exp_t a;
        if (done16 && !done16_q) begin
            a = '{rt0: rtime16[15:0], rt1: rtime16[31:16], valid: valid16,
                  fstart: fstart16, winner: winner16, win_ok: win_ok16, best: best16};
            if (q16.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done16_unexpected: got done with empty scoreboard, required none");
            end else begin
                cmp_result("w16", a, q16.pop_front());
            end
        end
        done16_q <= done16;
    end

    always @(negedge clk) begin
        exp_t a;
        if (done4 && !done4_q) begin
            a = '{rt0: {12'b0, rtime4[3:0]}, rt1: {12'b0, rtime4[7:4]}, valid: valid4,
                  fstart: fstart4, winner: winner4, win_ok: win_ok4, best: {12'b0, best4}};
            if (q4.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done4_unexpected: got done with empty scoreboard, required none");
            end else begin
                cmp_result("w4", a, q4.pop_front());
            end
        end
        done4_q <= done4;
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic go16(input logic [15:0] d);
        delay = d;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
    endtask

    task automatic go4(input logic [15:0] d);
        delay = d;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic wait_done16(input int budget);
        int k = 0;
        while (!done16 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_done16", {31'b0, done16}, 32'd1);
    endtask

    task automatic wait_done4(input int budget);
        int k = 0;
        while (!done4 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_done4", {31'b0, done4}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        repeat (3) @(negedge clk);
        chk("rst_lamp",   {31'b0, lamp16},   32'd0);
        chk("rst_busy",   {31'b0, busy16},   32'd0);
        chk("rst_done",   {31'b0, done16},   32'd0);
        chk("rst_valid",  {30'b0, valid16},  32'd0);
        chk("rst_win_ok", {31'b0, win_ok16}, 32'd0);
        chk("rst_best",   {16'b0, best16},   32'h0000ffff);
        chk("rst_best4",  {28'b0, best4},    32'h0000000f);
        rst = 1'b0;
        @(negedge clk);

        // T1: delay 3, ch0 at 5, ch1 at 9.
        q16.push_back('{rt0: 5, rt1: 9, valid: 2'b11, fstart: 2'b00, winner: 0, win_ok: 1, best: 5});
        go16(3);
        chk("t1_busy_delay", {31'b0, busy16}, 32'd1);
        tick_n(3);
        chk("t1_lamp_before", {31'b0, lamp16}, 32'd0);
        tick_n(1);
        chk("t1_lamp_run", {31'b0, lamp16}, 32'd1);
        tick_n(5);
        resp16 = 2'b01;
        tick_n(4);
        resp16 = 2'b11;
        wait_done16(20);
        resp16 = 2'b00;
        @(negedge clk);

        // T2: ch1 false start, ch0 at 4.
        q16.push_back('{rt0: 4, rt1: 0, valid: 2'b01, fstart: 2'b10, winner: 0, win_ok: 1, best: 4});
        go16(3);
        tick_n(1);
        resp16 = 2'b10;
        @(negedge clk);
        tick_n(3);
        chk("t2_lamp_run", {31'b0, lamp16}, 32'd1);
        tick_n(4);
        resp16 = 2'b11;
        wait_done16(20);
        resp16 = 2'b00;
        @(negedge clk);

        // T3: simultaneous edges with tick at elapsed 7.
        q16.push_back('{rt0: 7, rt1: 7, valid: 2'b11, fstart: 2'b00, winner: 0, win_ok: 1, best: 4});
        go16(2);
        tick_n(3);
        tick_n(7);
        resp16 = 2'b11;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        wait_done16(20);
        resp16 = 2'b00;
        @(negedge clk);

        // T4: delay 0, ch1 faster, start during RUN ignored.
        q16.push_back('{rt0: 3, rt1: 2, valid: 2'b11, fstart: 2'b00, winner: 1, win_ok: 1, best: 2});
        go16(0);
        tick_n(1);
        tick_n(2);
        resp16 = 2'b10;
        @(negedge clk);
        go16(7);
        tick_n(1);
        resp16 = 2'b11;
        wait_done16(20);
        resp16 = 2'b00;
        @(negedge clk);

        // T5: all channels false start; lamp never lit.
        q16.push_back('{rt0: 0, rt1: 0, valid: 2'b00, fstart: 2'b11, winner: 0, win_ok: 0, best: 2});
        seen = 1'b0;
        go16(5);
        tick = 1'b1;
        @(negedge clk);
        seen = seen | lamp16;
        tick = 1'b0;
        @(negedge clk);
        resp16 = 2'b11;
        repeat (2) begin
            @(negedge clk);
            seen = seen | lamp16;
        end
        wait_done16(20);
        chk("t5_lamp_never", {31'b0, seen}, 32'd0);
        resp16 = 2'b00;
        @(negedge clk);

        // T6: WIDTH=4, no responses, saturate at 15.
        q4.push_back('{rt0: 0, rt1: 0, valid: 2'b00, fstart: 2'b00, winner: 0, win_ok: 0, best: 16'h000f});
        go4(1);
        tick_n(2);
        chk("t6_lamp4", {31'b0, lamp4}, 32'd1);
        tick_n(14);
        chk("t6_busy4_at14", {31'b0, busy4}, 32'd1);
        tick_n(1);
        wait_done4(20);

        // T7: reset mid-RUN, then delay 0 lights lamp on first tick.
        go16(0);
        tick_n(1);
        tick_n(2);
        resp16 = 2'b01;
        @(negedge clk);
        chk("t7_valid_pre", {30'b0, valid16}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t7_rst_lamp",   {31'b0, lamp16},   32'd0);
        chk("t7_rst_busy",   {31'b0, busy16},   32'd0);
        chk("t7_rst_rtime",  rtime16,           32'd0);
        chk("t7_rst_valid",  {30'b0, valid16},  32'd0);
        chk("t7_rst_fstart", {30'b0, fstart16}, 32'd0);
        chk("t7_rst_winner", {29'b0, winner16}, 32'd0);
        chk("t7_rst_best",   {16'b0, best16},   32'h0000ffff);
        @(negedge clk);
        rst = 1'b0;
        resp16 = 2'b00;
        @(negedge clk);
        go16(0);
        chk("t7_lamp_pre_tick", {31'b0, lamp16}, 32'd0);
        chk("t7_busy_accept",   {31'b0, busy16}, 32'd1);
        tick_n(1);
        chk("t7_lamp_first_tick", {31'b0, lamp16}, 32'd1);

        chk("q16_drained", q16.size(), 32'd0);
        chk("q4_drained",  q4.size(),  32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
